pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the single-cycle CPU: holds the PC register and selects the next PC from sequential, branch, jump, jump-register, exception and exception-return sources. Replaces the bare PC-increment adder plus external PC register and NPC mux with one clocked block carrying stall, trap and EPC state. Sits at the head of the datapath and feeds instruction memory address and the link value.

## Interface
- WIDTH, 32, PC/address width in bits; must be ≥ 32
- STEP, 4, sequential increment in bytes
- RESET_PC, 32'h0000_3000, PC value loaded by reset
- EXC_VECTOR, 32'h0000_4180, handler entry address
- clk  input  1  system clock; one clock domain
- rst_n  input  1  reset; asynchronous, active-low
- stall  input  1  hold PC this cycle
- npc_sel  input  2  0 SEQ, 1 BRANCH, 2 JUMP, 3 JR
- branch_taken  input  1  qualifies BRANCH; when 0, BRANCH behaves as SEQ
- br_offset  input  WIDTH  sign-extended word offset
- jump_index  input  26  J/JAL instruction index
- jr_target  input  WIDTH  register value for JR
- exc_req  input  1  external exception request
- eret  input  1  return from handler
- pc  output  WIDTH  current PC (registered)
- pc_plus  output  WIDTH  pc + STEP (combinational)
- epc  output  WIDTH  captured exception PC (registered)
- in_trap  output  1  1 while in TRAP state
- exc_taken  output  1  one-cycle registered pulse, exception redirect occurred
- valid  output  1  0 during BOOT cycle, else 1

## Operation
- FSM states BOOT, RUN, TRAP. Reset → BOOT. BOOT → RUN unconditionally next edge; PC holds RESET_PC in BOOT (inputs ignored).
- Targets (all mod 2^WIDTH, wrap silently): SEQ = pc + STEP; BRANCH = pc + STEP + (br_offset << 2); JUMP = {pc_plus[WIDTH-1:28], jump_index, 2'b00}; JR = jr_target.
- jr_misaligned = (npc_sel==JR) && jr_target[1:0] != 0; treated as an exception source.
- Per-edge priority in RUN: (1) exc_req or jr_misaligned → pc ← EXC_VECTOR, epc ← pc, state → TRAP, exc_taken ← 1; (2) eret ignored in RUN; (3) stall → pc holds; (4) else pc ← selected target.
- In TRAP: exc_req and jr_misaligned ignored (no nesting; misaligned JR then takes jr_target unchanged); eret → pc ← epc, state → RUN (eret overrides stall); else stall/npc_sel as RUN.
- Exception overrides stall. epc only written on exception entry.

## Timing
- All state updates on posedge clk; rst_n low clears immediately regardless of clk.
- Reset values: pc = RESET_PC, epc = 0, in_trap = 0, exc_taken = 0, valid = 0, state BOOT; pc_plus = RESET_PC + STEP.
- Redirect latency: inputs sampled at edge N, new pc visible after edge N; no bubbles.
- exc_taken high exactly one cycle following the redirect edge.
- rst_n asserted mid-TRAP: exits to BOOT, epc cleared, in_trap 0.
- pc = 2^WIDTH − STEP with SEQ → pc = 0 next cycle.

## Structure
- Package pc_pkg: npc_sel encodings (NPC_SEQ/BRANCH/JUMP/JR), state enum (ST_BOOT/ST_RUN/ST_TRAP), default RESET_PC and EXC_VECTOR constants.
- One sub-module: pc_step_adder (WIDTH, STEP) producing pc_plus; instantiated once, target arithmetic otherwise in pc_unit.

## Test plan
- Reset release: rst_n 0→1 → pc 0x3000, valid 0 for one cycle, then SEQ gives 0x3004, 0x3008.
- Branch back: pc 0x3010, npc_sel 1, branch_taken 1, br_offset 0xFFFF_FFFE → pc 0x300C; branch_taken 0 → 0x3014.
- Stall vs jump: pc 0x3000, stall 1, npc_sel 2, jump_index 0x0000C10 → pc holds 0x3000; stall 0 → pc 0x3040.
- Exception under stall: pc 0x3020, stall 1, exc_req 1 → pc 0x4180, epc 0x3020, in_trap 1, exc_taken one-cycle pulse; second exc_req in TRAP → no change to epc.
- Misaligned JR then eret: pc 0x3000, npc_sel 3, jr_target 0x3006 → pc 0x4180, epc 0x3000; eret → pc 0x3000, in_trap 0.
- Wrap and async reset: pc 0xFFFF_FFFC SEQ → 0x0; rst_n low mid-TRAP between edges → pc 0x3000, epc 0, in_trap 0 immediately.

Source files
------------

// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter unit.
//   - npc_sel encodings (next-PC source select)
//   - FSM state encoding
//   - default reset PC and exception vector
package pc_pkg;

    localparam int NPC_SEL_W = 2;

    typedef enum logic [NPC_SEL_W-1:0] {
        NPC_SEQ    = 2'd0,
        NPC_BRANCH = 2'd1,
        NPC_JUMP   = 2'd2,
        NPC_JR     = 2'd3
    } npc_sel_e;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_TRAP = 2'd2
    } pc_state_e;

    localparam logic [31:0] DEF_RESET_PC   = 32'h0000_3000;
    localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_4180;

endpackage

// File: rtl/pc_unit_if.sv
// pc_unit_if: control/target inputs and PC-state outputs of the program-counter unit.
//   master : datapath/decoder side (drives select, targets, stall, exception controls)
//   slave  : pc_unit side (returns pc, pc_plus, epc, in_trap, exc_taken, valid)
interface pc_unit_if
    import pc_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic                 stall;
    logic [NPC_SEL_W-1:0] npc_sel;
    logic                 branch_taken;
    logic [WIDTH-1:0]     br_offset;
    logic [25:0]          jump_index;
    logic [WIDTH-1:0]     jr_target;
    logic                 exc_req;
    logic                 eret;

    logic [WIDTH-1:0]     pc;
    logic [WIDTH-1:0]     pc_plus;
    logic [WIDTH-1:0]     epc;
    logic                 in_trap;
    logic                 exc_taken;
    logic                 valid;

    modport master (
        output stall, npc_sel, branch_taken, br_offset, jump_index, jr_target, exc_req, eret,
        input  pc, pc_plus, epc, in_trap, exc_taken, valid
    );

    modport slave (
        input  stall, npc_sel, branch_taken, br_offset, jump_index, jr_target, exc_req, eret,
        output pc, pc_plus, epc, in_trap, exc_taken, valid
    );
endinterface

// File: rtl/pc_step_adder.sv
// pc_step_adder: sequential-PC incrementer, o_pc_plus = i_pc + STEP (wraps mod 2^WIDTH).
//   i_pc      : current PC
//   o_pc_plus : PC of the next sequential instruction, also the link value
module pc_step_adder #(
    parameter int          WIDTH = 32,
    parameter int unsigned STEP  = 4
) (
    input  logic [WIDTH-1:0] i_pc,
    output logic [WIDTH-1:0] o_pc_plus
);
    assign o_pc_plus = i_pc + WIDTH'(STEP);
endmodule

// File: rtl/pc_unit.sv
// pc_unit: PC register, next-PC selection, stall, exception entry/return and EPC.
//   clk, rst_n : system clock; asynchronous active-low reset
//   bus.slave  : stall, npc_sel, branch_taken, br_offset, jump_index, jr_target,
//                exc_req, eret in; pc, pc_plus, epc, in_trap, exc_taken, valid out
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_BOOT | first cycle after reset; pc = RESET_PC, inputs ignored
// ST_RUN  | normal fetch; exceptions and misaligned JR enter ST_TRAP
// ST_TRAP | inside handler; no nesting, eret returns to epc
module pc_unit
    import pc_pkg::*;
#(
    parameter int              WIDTH      = 32,
    parameter int unsigned     STEP       = 4,
    parameter logic [WIDTH-1:0] RESET_PC   = WIDTH'(DEF_RESET_PC),
    parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(DEF_EXC_VECTOR)
) (
    input  logic      clk,
    input  logic      rst_n,
    pc_unit_if.slave  bus
);

    pc_state_e        r_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_epc;
    logic             r_exc_taken;

    pc_state_e        w_state_nxt;
    logic [WIDTH-1:0] w_pc_nxt;
    logic [WIDTH-1:0] w_epc_nxt;
    logic             w_exc_taken_nxt;
    logic [WIDTH-1:0] w_pc_plus;
    logic [WIDTH-1:0] w_target;
    logic             w_jr_misaligned;
    logic             w_exc_entry;

    pc_step_adder #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step_adder (
        .i_pc      (r_pc),
        .o_pc_plus (w_pc_plus)
    );

    // Target selection; a not-taken branch falls through to the sequential PC.
    always_comb begin
        w_target = w_pc_plus;
        case (bus.npc_sel)
            NPC_SEQ:    w_target = w_pc_plus;
            NPC_BRANCH: w_target = bus.branch_taken ? (w_pc_plus + (bus.br_offset << 2)) : w_pc_plus;
            NPC_JUMP:   w_target = {w_pc_plus[WIDTH-1:28], bus.jump_index, 2'b00};
            NPC_JR:     w_target = bus.jr_target;
            default:    w_target = w_pc_plus;
        endcase
    end

    assign w_jr_misaligned = (bus.npc_sel == NPC_JR) && (bus.jr_target[1:0] != 2'b00);
    assign w_exc_entry     = bus.exc_req || w_jr_misaligned;

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_epc_nxt       = r_epc;
        w_exc_taken_nxt = 1'b0;
        case (r_state)
            ST_BOOT: begin
                w_state_nxt = ST_RUN;
                w_pc_nxt    = RESET_PC;
            end
            ST_RUN: begin
                // Exception beats stall; eret has no meaning outside the handler.
                if (w_exc_entry) begin
                    w_pc_nxt        = EXC_VECTOR;
                    w_epc_nxt       = r_pc;
                    w_state_nxt     = ST_TRAP;
                    w_exc_taken_nxt = 1'b1;
                end else if (!bus.stall) begin
                    w_pc_nxt = w_target;
                end
            end
            ST_TRAP: begin
                // No nesting: a misaligned JR here simply jumps to jr_target.
                if (bus.eret) begin
                    w_pc_nxt    = r_epc;
                    w_state_nxt = ST_RUN;
                end else if (!bus.stall) begin
                    w_pc_nxt = w_target;
                end
            end
            default: begin
                w_state_nxt = ST_BOOT;
                w_pc_nxt    = RESET_PC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_BOOT;
            r_pc        <= RESET_PC;
            r_epc       <= '0;
            r_exc_taken <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_epc       <= w_epc_nxt;
            r_exc_taken <= w_exc_taken_nxt;
        end
    end

    assign bus.pc        = r_pc;
    assign bus.pc_plus   = w_pc_plus;
    assign bus.epc       = r_epc;
    assign bus.in_trap   = (r_state == ST_TRAP);
    assign bus.exc_taken = r_exc_taken;
    assign bus.valid     = (r_state != ST_BOOT);

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed and randomized checks of pc_unit against a behavioural model.
module tb_pc_unit;
    import pc_pkg::*;

    localparam int W = 32;

    logic clk;
    logic rst_n;

    pc_unit_if #(.WIDTH(W)) bus();

    pc_unit #(
        .WIDTH      (W),
        .STEP       (4),
        .RESET_PC   (32'h0000_3000),
        .EXC_VECTOR (32'h0000_4180)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic        m_boot;
    logic        m_trap;
    logic        m_exc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_3000;
        m_epc  = 32'h0;
        m_boot = 1'b1;
        m_trap = 1'b0;
        m_exc  = 1'b0;
    endtask

    // One clock edge of the architectural rules, applied to the current inputs.
    task automatic model_edge();
        logic [31:0] seq;
        logic [31:0] tgt;
        logic        mis;
        seq = m_pc + 32'd4;
        case (bus.npc_sel)
            2'd1:    tgt = bus.branch_taken ? seq + bus.br_offset * 32'd4 : seq;
            2'd2:    tgt = (seq & 32'hF000_0000) | ({6'b0, bus.jump_index} * 32'd4);
            2'd3:    tgt = bus.jr_target;
            default: tgt = seq;
        endcase
        mis   = (bus.npc_sel == 2'd3) && (bus.jr_target % 4 != 0);
        m_exc = 1'b0;
        if (m_boot) begin
            m_boot = 1'b0;
        end else if (!m_trap && (bus.exc_req || mis)) begin
            m_epc  = m_pc;
            m_pc   = 32'h0000_4180;
            m_trap = 1'b1;
            m_exc  = 1'b1;
        end else if (m_trap && bus.eret) begin
            m_pc   = m_epc;
            m_trap = 1'b0;
        end else if (!bus.stall) begin
            m_pc = tgt;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, "_pc"},        bus.pc,              m_pc);
        chk({tag, "_pc_plus"},   bus.pc_plus,         m_pc + 32'd4);
        chk({tag, "_epc"},       bus.epc,             m_epc);
        chk({tag, "_in_trap"},   {31'b0, bus.in_trap},   {31'b0, m_trap});
        chk({tag, "_exc_taken"}, {31'b0, bus.exc_taken}, {31'b0, m_exc});
        chk({tag, "_valid"},     {31'b0, bus.valid},     {31'b0, !m_boot});
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic idle_inputs();
        bus.stall        = 1'b0;
        bus.npc_sel      = NPC_SEQ;
        bus.branch_taken = 1'b0;
        bus.br_offset    = '0;
        bus.jump_index   = '0;
        bus.jr_target    = '0;
        bus.exc_req      = 1'b0;
        bus.eret         = 1'b0;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        bus.npc_sel   = NPC_JR;
        bus.jr_target = target;
        step("goto");
        bus.npc_sel   = NPC_SEQ;
    endtask

    task automatic async_reset_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk({tag, "_pc"},      bus.pc,               32'h0000_3000);
        chk({tag, "_epc"},     bus.epc,              32'h0);
        chk({tag, "_in_trap"}, {31'b0, bus.in_trap}, 32'h0);
        chk({tag, "_valid"},   {31'b0, bus.valid},   32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_pc",        bus.pc,                 32'h0000_3000);
        chk("rst_pc_plus",   bus.pc_plus,            32'h0000_3004);
        chk("rst_epc",       bus.epc,                32'h0);
        chk("rst_in_trap",   {31'b0, bus.in_trap},   32'h0);
        chk("rst_exc_taken", {31'b0, bus.exc_taken}, 32'h0);
        chk("rst_valid",     {31'b0, bus.valid},     32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("release_valid", {31'b0, bus.valid}, 32'h0);

        // Reset release and sequential fetch
        step("boot");
        chk("boot_pc",    bus.pc,             32'h0000_3000);
        chk("boot_valid", {31'b0, bus.valid}, 32'h1);
        step("seq1");  chk("seq1_pc", bus.pc, 32'h0000_3004);
        step("seq2");  chk("seq2_pc", bus.pc, 32'h0000_3008);
        step("seq3");
        step("seq4");  chk("seq4_pc", bus.pc, 32'h0000_3010);

        // Backward branch, then not-taken branch
        bus.npc_sel      = NPC_BRANCH;
        bus.branch_taken = 1'b1;
        bus.br_offset    = 32'hFFFF_FFFE;
        step("br_back"); chk("br_back_pc", bus.pc, 32'h0000_300C);
        bus.npc_sel = NPC_SEQ;
        step("seq5");
        bus.npc_sel      = NPC_BRANCH;
        bus.branch_taken = 1'b0;
        step("br_nt"); chk("br_nt_pc", bus.pc, 32'h0000_3014);
        idle_inputs();

        // Stall holds against a jump, then jump proceeds
        goto_pc(32'h0000_3000);
        bus.stall      = 1'b1;
        bus.npc_sel    = NPC_JUMP;
        bus.jump_index = 26'h000_0C10;
        step("stall_jump"); chk("stall_jump_pc", bus.pc, 32'h0000_3000);
        bus.stall = 1'b0;
        step("jump"); chk("jump_pc", bus.pc, 32'h0000_3040);
        idle_inputs();

        // Exception under stall, nested request ignored, eret beats stall
        goto_pc(32'h0000_3020);
        bus.stall   = 1'b1;
        bus.exc_req = 1'b1;
        step("exc");
        chk("exc_pc",        bus.pc,                 32'h0000_4180);
        chk("exc_epc",       bus.epc,                32'h0000_3020);
        chk("exc_in_trap",   {31'b0, bus.in_trap},   32'h1);
        chk("exc_exc_taken", {31'b0, bus.exc_taken}, 32'h1);
        step("exc_nest");
        chk("exc_nest_epc",   bus.epc,                 32'h0000_3020);
        chk("exc_nest_pulse", {31'b0, bus.exc_taken}, 32'h0);
        bus.exc_req = 1'b0;
        bus.eret    = 1'b1;
        step("eret_stall");
        chk("eret_stall_pc",   bus.pc,               32'h0000_3020);
        chk("eret_stall_trap", {31'b0, bus.in_trap}, 32'h0);
        bus.stall = 1'b0;
        step("eret_in_run"); chk("eret_in_run_pc", bus.pc, 32'h0000_3024);
        idle_inputs();

        // Misaligned JR traps; inside the handler it is a plain jump
        goto_pc(32'h0000_3000);
        bus.npc_sel   = NPC_JR;
        bus.jr_target = 32'h0000_3006;
        step("jr_mis");
        chk("jr_mis_pc",  bus.pc,  32'h0000_4180);
        chk("jr_mis_epc", bus.epc, 32'h0000_3000);
        step("jr_mis_trap"); chk("jr_mis_trap_pc", bus.pc, 32'h0000_3006);
        bus.npc_sel = NPC_SEQ;
        bus.eret    = 1'b1;
        step("eret_jr");
        chk("eret_jr_pc",   bus.pc,               32'h0000_3000);
        chk("eret_jr_trap", {31'b0, bus.in_trap}, 32'h0);
        idle_inputs();

        // Wrap at top of address space, then async reset in TRAP
        goto_pc(32'hFFFF_FFFC);
        step("wrap"); chk("wrap_pc", bus.pc, 32'h0);
        bus.exc_req = 1'b1;
        step("wrap_exc");
        bus.exc_req = 1'b0;
        async_reset_check("arst_trap");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] jt;
            bus.stall        = ($urandom_range(3, 0) == 0);
            bus.npc_sel      = 2'($urandom_range(3, 0));
            bus.branch_taken = 1'($urandom);
            bus.br_offset    = 32'(int'($urandom_range(64, 0)) - 32);
            bus.jump_index   = 26'($urandom);
            jt = $urandom;
            if ($urandom_range(3, 0) != 0) jt[1:0] = 2'b00;
            bus.jr_target    = jt;
            bus.exc_req      = ($urandom_range(15, 0) == 0);
            bus.eret         = ($urandom_range(7, 0) == 0);
            step("rand");
            if (i == 200) begin
                idle_inputs();
                async_reset_check("arst_rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
